// File: rtl/pulse_swallow_ctrl.sv
// Program/swallow counter pair closing the loop around a /3-/4 prescaler.
// Define PSC_TOGGLE_OUT_EN for a toggling 50% duty clk_out instead of pulses.
module pulse_swallow_ctrl #(
  parameter int W     = 6,
  parameter int P_RST = 4,
  parameter int S_RST = 0
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic [W-1:0] p_val,
  input  logic [W-1:0] s_val,
  input  logic         load,
  output logic         mod,
  output logic         clk_out,
  output logic         cfg_err,
  output logic         busy
);

  localparam logic [W-1:0] P_INIT = W'(P_RST);
  localparam logic [W-1:0] S_INIT = W'(S_RST);
  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W-1:0] TWO    = W'(2);

  logic [W-1:0] cnt, p_act, s_act, p_pend, s_pend;

  logic [W-1:0] cnt_nxt, p_nxt, s_nxt, p_pend_nxt, s_pend_nxt;
  logic         wrap, apply, load_ok;
  logic         mod_nxt, out_nxt, busy_nxt, err_nxt;

  always_comb begin
    wrap       = (cnt == p_act - ONE);
    apply      = wrap && busy;
    load_ok    = (p_val >= TWO) && (s_val <= p_val);
    p_nxt      = p_act;
    s_nxt      = s_act;
    p_pend_nxt = p_pend;
    s_pend_nxt = s_pend;
    busy_nxt   = busy;
    err_nxt    = cfg_err;
    if (apply) begin
      p_nxt    = p_pend;
      s_nxt    = s_pend;
      busy_nxt = 1'b0;
    end
    // A load on the boundary edge only fills pending; the older one applies now
    if (load) begin
      err_nxt = !load_ok;
      if (load_ok) begin
        p_pend_nxt = p_val;
        s_pend_nxt = s_val;
        busy_nxt   = 1'b1;
      end
    end
    cnt_nxt = wrap ? '0 : cnt + ONE;
    mod_nxt = (cnt_nxt < s_nxt);
`ifdef PSC_TOGGLE_OUT_EN
    out_nxt = wrap ? !clk_out : clk_out;
`else
    out_nxt = (cnt_nxt == p_nxt - ONE);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      p_act   <= P_INIT;
      s_act   <= S_INIT;
      p_pend  <= '0;
      s_pend  <= '0;
      busy    <= 1'b0;
      cfg_err <= 1'b0;
      mod     <= (S_RST > 0);
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      p_act   <= p_nxt;
      s_act   <= s_nxt;
      p_pend  <= p_pend_nxt;
      s_pend  <= s_pend_nxt;
      busy    <= busy_nxt;
      cfg_err <= err_nxt;
      mod     <= mod_nxt;
      clk_out <= out_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// Randomized self-checking bench for pulse_swallow_ctrl.
// Reference model tracks frame position k and the active/pending config.
module tb_pulse_swallow_ctrl;

  localparam int W     = 6;
  localparam int P_RST = 4;
  localparam int S_RST = 0;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] p_val = '0;
  logic [W-1:0] s_val = '0;
  logic         mod, clk_out, cfg_err, busy;

  int n_checks = 0;
  int n_pass   = 0;

  int m_k, m_p, m_s, m_pp, m_ps;
  bit m_busy, m_err, m_tog;

  pulse_swallow_ctrl #(.W(W), .P_RST(P_RST), .S_RST(S_RST)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .p_val   (p_val),
    .s_val   (s_val),
    .load    (load),
    .mod     (mod),
    .clk_out (clk_out),
    .cfg_err (cfg_err),
    .busy    (busy)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [3:0] exp_vec();
    logic eo;
`ifdef PSC_TOGGLE_OUT_EN
    eo = m_tog;
`else
    eo = (m_k == m_p - 1);
`endif
    return {logic'(m_k < m_s), eo, logic'(m_busy), logic'(m_err)};
  endfunction

  function automatic logic [3:0] dut_vec();
    return {mod, clk_out, busy, cfg_err};
  endfunction

  // One clk_in cycle: drive inputs, take the edge, advance the model.
  task automatic cycle(input bit r, input bit ld, input int pv, input int sv);
    int pm, sm;
    pm = pv % (1 << W);
    sm = sv % (1 << W);
    rst = r; load = ld; p_val = W'(pm); s_val = W'(sm);
    @(posedge clk_in);
    if (r) begin
      m_k = 0; m_p = P_RST; m_s = S_RST;
      m_busy = 0; m_err = 0; m_tog = 0;
    end else begin
      if (m_k == m_p - 1) begin
        m_k = 0;
        m_tog = !m_tog;
        if (m_busy) begin
          m_p = m_pp; m_s = m_ps; m_busy = 0;
        end
      end else begin
        m_k++;
      end
      if (ld) begin
        if (pm >= 2 && sm <= pm) begin
          m_pp = pm; m_ps = sm; m_busy = 1; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end
    #1;
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== 4'b0000)
      $display("FAIL reset: got %b want 0000", dut_vec());
    else n_pass++;
  endtask

  task automatic test_default_pattern();
    int highs = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL default_pat c%0d: got %b want %b", i, dut_vec(), exp_vec());
      else n_pass++;
      if (mod !== 1'b0 || busy !== 1'b0) highs = -100;
    end
    n_checks++;
    if (highs < 0)
      $display("FAIL default_mod_busy: got nonzero want 0");
    else n_pass++;
  endtask

  task automatic test_load_apply();
    int t = 0;
    int sum = 0;
    cycle(0, 1, 5, 2);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL load_busy: got %b want 1", busy);
    else n_pass++;
    while (busy === 1'b1 && t < 20) begin
      cycle(0, 0, 0, 0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL load_wait: got %b want %b", dut_vec(), exp_vec());
      else n_pass++;
      t++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL load_apply_timeout: busy got %b want 0", busy);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      sum += mod ? 4 : 3;
      cycle(0, 0, 0, 0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL p5s2 c%0d: got %b want %b", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (sum != 17) $display("FAIL prescaler_count: got %0d want 17", sum);
    else n_pass++;
  endtask

  task automatic test_invalid_load();
    cycle(0, 1, 5, 6);
    n_checks++;
    if ({cfg_err, busy} !== 2'b10)
      $display("FAIL bad_load1: got %b want 10", {cfg_err, busy});
    else n_pass++;
    cycle(0, 1, 1, 0);
    n_checks++;
    if ({cfg_err, busy} !== 2'b10)
      $display("FAIL bad_load2: got %b want 10", {cfg_err, busy});
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL bad_load_pat c%0d: got %b want %b", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_last_wins();
    int t = 0;
    cycle(0, 1, 6, 6);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 3, 1);
    while (busy === 1'b1 && t < 20) begin
      cycle(0, 0, 0, 0);
      t++;
    end
    n_checks++;
    if (busy !== 1'b0 || m_p != 3)
      $display("FAIL last_wins_apply: busy %b P %0d want 0 3", busy, m_p);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if ({mod, clk_out} !== {logic'(i % 3 == 0), logic'(i % 3 == 2)} &&
          `ifdef PSC_TOGGLE_OUT_EN 1'b0 `else 1'b1 `endif)
        $display("FAIL last_wins c%0d: got %b%b", i, mod, clk_out);
      else if (dut_vec() !== exp_vec())
        $display("FAIL last_wins_m c%0d: got %b want %b", i, dut_vec(), exp_vec());
      else n_pass++;
      cycle(0, 0, 0, 0);
    end
  endtask

  task automatic test_reset_midframe();
    int t = 0;
    cycle(0, 1, 5, 0);
    while ((m_busy || m_k != 2) && t < 30) begin
      cycle(0, 0, 0, 0);
      t++;
    end
    n_checks++;
    if (m_k != 2) $display("FAIL midframe_reach: k %0d want 2", m_k);
    else n_pass++;
    cycle(0, 1, 7, 3);
    cycle(1, 0, 0, 0);
    n_checks++;
    if (dut_vec() !== 4'b0000)
      $display("FAIL midframe_rst: got %b want 0000", dut_vec());
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL post_rst c%0d: got %b want %b", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_boundary_load();
    int t = 0;
    cycle(0, 1, 6, 2);
    while (m_k != m_p - 1 && t < 30) begin
      cycle(0, 0, 0, 0);
      t++;
    end
    cycle(0, 1, 3, 3);
    n_checks++;
    if (busy !== 1'b1 || m_p != 6)
      $display("FAIL boundary_load: busy %b P %0d want 1 6", busy, m_p);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL boundary c%0d: got %b want %b", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 12), $urandom_range(0, 12));
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random c%0d: got %b want %b", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    m_k = 0; m_p = P_RST; m_s = S_RST; m_pp = 0; m_ps = 0;
    m_busy = 0; m_err = 0; m_tog = 0;
    #2;
    test_reset();
    test_default_pattern();
    test_load_apply();
    test_invalid_load();
    test_last_wins();
    test_reset_midframe();
    test_boundary_load();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
